// File: rtl/imem_loader.sv
// Streams host instruction words into the CPU instruction memory from address 0,
// then releases the CPU with cpu_enable and a single cpu_start pulse.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int SETTLE = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W:0]  FULL_COUNT  = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;

    logic                accept;
    logic [ADDR_W:0]     base_count;
    logic [ADDR_W:0]     next_count;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on the state register, never on in_valid.
    assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept     = in_valid && in_ready;
    assign base_count = (state_q == S_IDLE) ? '0 : word_count_q;
    assign next_count = base_count + 1'b1;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_count_d = word_count_q;

        // The write lands one cycle after acceptance; the count advances with it.
        if (accept) begin
            we_d         = 1'b1;
            addr_d       = base_count[ADDR_W-1:0];
            wdata_d      = in_data;
            word_count_d = next_count;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last ? S_SETTLE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = S_SETTLE;
                    end else if (next_count == FULL_COUNT) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_START;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (load_req) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_count_q <= word_count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;
    assign cpu_enable = (state_q == S_SETTLE) || (state_q == S_START) || (state_q == S_RUN);
    assign cpu_start  = (state_q == S_START);
    assign busy       = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_START);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Drives two loaders (256-word and 4-word address spaces) with the same host stream
// and checks both against a timeline model of the load/settle/start sequence.
module tb_imem_loader;

    localparam int SETTLE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        load_req = 1'b0;

    logic        ready_a, we_a, en_a, start_a, busy_a, err_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic [8:0]  wc_a;

    logic        ready_b, we_b, en_b, start_b, busy_b, err_b;
    logic [1:0]  addr_b;
    logic [15:0] wdata_b;
    logic [2:0]  wc_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model, one slot per instance.
    int depth [2] = '{256, 4};
    int m_cnt [2];
    int m_done[2];
    bit m_open [2];
    bit m_fresh[2];
    bit m_err  [2];
    bit m_rst  [2];
    logic [23:0] exp_q_a[$];
    logic [23:0] exp_q_b[$];

    always #5 clock = ~clock;

    imem_loader #(.ADDR_W(8), .DATA_W(16), .SETTLE(SETTLE)) u_dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(ready_a), .load_req(load_req), .imem_we(we_a),
        .imem_addr(addr_a), .imem_wdata(wdata_a), .cpu_enable(en_a), .cpu_start(start_a),
        .busy(busy_a), .error(err_a), .word_count(wc_a)
    );

    imem_loader #(.ADDR_W(2), .DATA_W(16), .SETTLE(SETTLE)) u_dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(ready_b), .load_req(load_req), .imem_we(we_b),
        .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_enable(en_b), .cpu_start(start_b),
        .busy(busy_b), .error(err_b), .word_count(wc_b)
    );

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        int base;
        if (reset) begin
            m_cnt[i] = 0; m_done[i] = -1; m_open[i] = 1; m_fresh[i] = 1;
            m_err[i] = 0; m_rst[i] = 1;
        end else begin
            m_rst[i] = 0;
            if (m_open[i] && in_valid) begin
                base = m_fresh[i] ? 0 : m_cnt[i];
                if (i == 0) exp_q_a.push_back({8'(base), in_data});
                else        exp_q_b.push_back({8'(base), in_data});
                m_cnt[i]   = base + 1;
                m_fresh[i] = 0;
                if (in_last) begin
                    m_open[i] = 0;
                    m_done[i] = cyc;
                end else if (m_cnt[i] == depth[i]) begin
                    m_open[i] = 0;
                    m_err[i]  = 1;
                end
            end else if (m_done[i] >= 0 && cyc >= m_done[i] + SETTLE + 2 && load_req) begin
                m_open[i] = 1; m_fresh[i] = 1; m_done[i] = -1;
            end
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    task automatic mon(input int i, input logic rdy, input logic en, input logic st,
                       input logic bsy, input logic er, input logic [8:0] wc,
                       input logic we, input logic [7:0] addr, input logic [15:0] wd);
        logic [23:0] e;
        int n;
        bit done_v;
        done_v = (m_done[i] >= 0);
        chk("in_ready",   i, rdy, m_open[i]);
        chk("cpu_enable", i, en,  done_v && cyc >= m_done[i]);
        chk("cpu_start",  i, st,  done_v && cyc == m_done[i] + SETTLE);
        chk("busy",       i, bsy, (m_open[i] && !m_fresh[i]) || (done_v && cyc <= m_done[i] + SETTLE));
        chk("error",      i, er,  m_err[i]);
        chk("word_count", i, wc,  m_cnt[i]);
        n = (i == 0) ? exp_q_a.size() : exp_q_b.size();
        chk("imem_we", i, we, n != 0);
        if (n != 0) begin
            e = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            if (we) begin
                chk("imem_addr",  i, addr, e[23:16]);
                chk("imem_wdata", i, wd,   e[15:0]);
            end
        end
        if (m_rst[i]) begin
            chk("reset_addr",  i, addr, 0);
            chk("reset_wdata", i, wd,   0);
        end
    endtask

    always @(negedge clock) begin
        mon(0, ready_a, en_a, start_a, busy_a, err_a, wc_a, we_a, addr_a, wdata_a);
        mon(1, ready_b, en_b, start_b, busy_b, err_b, {6'd0, wc_b}, we_b, {6'd0, addr_b}, wdata_b);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [15:0] d, input logic l, input logic v);
        in_valid = v; in_data = d; in_last = l;
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n, budget;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Three-word program, valid every cycle.
        put(16'h1234, 0, 1); put(16'h5678, 0, 1); put(16'hABCD, 1, 1);
        idle(6);

        // Same program with gaps; data on idle cycles must be ignored.
        pulse_load();
        idle(1);
        put(16'h1234, 0, 1); put(16'hDEAD, 0, 0); put(16'h5678, 0, 1);
        put(16'hBEEF, 1, 0); put(16'hABCD, 1, 1);
        idle(6);

        // Single-word program straight from IDLE.
        pulse_load();
        put(16'h00FF, 1, 1);
        idle(6);

        // Five words without last: the 4-word loader overflows, then a full legal program.
        pulse_load();
        for (int k = 0; k < 5; k++) put(16'h1000 + 16'(k), 0, 1);
        idle(3);
        do_reset();
        for (int k = 0; k < 4; k++) put(16'h2000 + 16'(k), k == 3, 1);
        idle(6);

        // Abort from RUN and reload a short program.
        pulse_load();
        put(16'h0A0A, 0, 1); put(16'h0B0B, 1, 1);
        idle(6);

        // Reset lands mid-settle: no start pulse may follow.
        pulse_load();
        put(16'h1111, 0, 1); put(16'h2222, 0, 1); put(16'h3333, 1, 1);
        do_reset();
        idle(8);

        // Randomized programs with gaps and stray load_req.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            n = $urandom_range(1, 6);
            budget = 0;
            while (m_cnt[0] < n && budget < 40) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 16'($urandom);
                in_last  = (m_cnt[0] == n - 1);
                load_req = ($urandom_range(0, 3) == 0);
                step();
                budget++;
            end
            in_valid = 1'b0; in_last = 1'b0;
            for (int k = 0; k < SETTLE + 5; k++) begin
                load_req = ($urandom_range(0, 7) == 0);
                step();
            end
            load_req = 1'b0;
        end

        idle(2);
        chk("leftover_writes", 0, exp_q_a.size(), 0);
        chk("leftover_writes", 1, exp_q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
